// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 encodings and fault cause codes for the data-memory responder
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10,
    FC_FUNCT3   = 2'b11
  } fault_cause_e;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores, lane select/extension for loads, access legality
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_illegal
);
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_shift = i_rword >> {i_addr, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr[1] ? i_rword[31:16] : i_rword[15:0];
  // store lane enables and replicated data, load extension, legality checks
  always_comb begin
    o_be       = i_funct3 == F3_B ? 4'b0001 << i_addr :
                 i_funct3 == F3_H ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    o_wdata    = i_funct3 == F3_B ? {4{i_wdata[7:0]}} :
                 i_funct3 == F3_H ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata    = i_funct3 == F3_B  ? {{24{w_byte[7]}}, w_byte} :
                 i_funct3 == F3_H  ? {{16{w_half[15]}}, w_half} :
                 i_funct3 == F3_BU ? {24'd0, w_byte} :
                 i_funct3 == F3_HU ? {16'd0, w_half} : i_rword;
    o_illegal  = i_store ? (i_funct3 > F3_W) : !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    o_misalign = (i_funct3[1:0] == 2'b01 && i_addr[0]) || (i_funct3[1:0] == 2'b10 && i_addr != 2'b00);
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data memory with one-entry pending store, read forwarding and sticky fault status
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadDataM,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  input  logic        fault_clear
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  logic [31:0]  r_mem [DEPTH_WORDS];
  logic         r_pend_valid;
  logic [AW-1:0] r_pend_idx;
  logic [31:0]  r_pend_data;
  logic [3:0]   r_pend_be;
  logic         r_fault_valid;
  fault_cause_e r_fault_cause;
  logic [31:0]  r_fault_addr;
  logic [31:0]  w_off;
  logic [AW-1:0] w_idx;
  logic         w_range;
  logic [31:0]  w_raw;
  logic [31:0]  w_merged;
  logic         w_hit;
  logic [3:0]   w_be;
  logic [31:0]  w_wdata;
  logic [31:0]  w_rdata;
  logic         w_misalign;
  logic         w_illegal;
  fault_cause_e w_cause;
  logic         w_fault;
  logic         w_accept;
  assign w_off   = Mem_WrAddr - BASE_ADDR;
  assign w_idx   = w_off[AW+1:2];
  assign w_range = {1'b0, w_off} >= 33'(DEPTH_WORDS) * 33'd4;
  assign w_raw   = r_mem[w_idx];
  assign w_hit   = r_pend_valid && r_pend_idx == w_idx;
  for (genvar g = 0; g < 4; g++) begin : g_merge
    assign w_merged[8*g +: 8] = (w_hit && r_pend_be[g]) ? r_pend_data[8*g +: 8] : w_raw[8*g +: 8];
  end
  dmem_lane_align u_align (
    .i_funct3  (funct3M),
    .i_addr    (w_off[1:0]),
    .i_store   (MemWriteM),
    .i_wdata   (Mem_WrData),
    .i_rword   (w_merged),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata),
    .o_misalign(w_misalign),
    .o_illegal (w_illegal)
  );
  // classify the request in priority order and decide whether a store is accepted
  always_comb begin
    w_cause   = w_illegal ? FC_FUNCT3 : w_range ? FC_RANGE : w_misalign ? FC_MISALIGN : FC_NONE;
    w_fault   = (MemReadM || MemWriteM) && w_cause != FC_NONE;
    w_accept  = MemWriteM && !w_fault;
    ReadDataM = (MemReadM && !w_fault) ? w_rdata : 32'd0;
  end
  // pending-store register: holds exactly the store accepted in the previous cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_data  <= '0;
      r_pend_be    <= '0;
    end else begin
      r_pend_valid <= w_accept;
      if (w_accept) begin
        r_pend_idx  <= w_idx;
        r_pend_data <= w_wdata;
        r_pend_be   <= w_be;
      end
    end
  end
  // commit the pending store into the array; a reset in the same cycle discards it
  always_ff @(posedge clk) begin
    if (r_pend_valid && !reset)
      for (int i = 0; i < 4; i++)
        if (r_pend_be[i]) r_mem[r_pend_idx][8*i +: 8] <= r_pend_data[8*i +: 8];
  end
  // sticky fault capture; a new fault outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault_valid <= 1'b0;
      r_fault_cause <= FC_NONE;
      r_fault_addr  <= '0;
    end else if (w_fault && (!r_fault_valid || fault_clear)) begin
      r_fault_valid <= 1'b1;
      r_fault_cause <= w_cause;
      r_fault_addr  <= Mem_WrAddr;
    end else if (fault_clear) begin
      r_fault_valid <= 1'b0;
      r_fault_cause <= FC_NONE;
      r_fault_addr  <= '0;
    end
  end
  assign fault_valid = r_fault_valid;
  assign fault_cause = r_fault_cause;
  assign fault_addr  = r_fault_addr;
endmodule
